// File: rtl/mean32_pkg.sv
// Shared constants and state encoding for the 32-sample mean calculator.
package mean32_pkg;

  localparam int unsigned N_ELEM = 32;
  localparam int unsigned DW     = 8;
  localparam int unsigned SUM_W  = 13;
  localparam int unsigned SHIFT  = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIN
  } state_e;

endpackage

// File: rtl/lane_adder.sv
// Combinational sum of LANES unsigned samples into a SUM_W-bit result.
module lane_adder
  import mean32_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic [DW-1:0]    lanes [LANES],
  output logic [SUM_W-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      sum = sum + SUM_W'(lanes[l]);
    end
  end

endmodule

// File: rtl/mean32_calc.sv
// Truncated mean of 32 unsigned 8-bit samples, consuming LANES samples per accumulate cycle.
module mean32_calc
  import mean32_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] data [1:N_ELEM],
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] mean
);

  localparam int unsigned IW = 6;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_ELEM - LANES + 1);

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   acc_q;
  logic [IW-1:0]      idx_q;
  logic [DW-1:0]      mean_q;

  logic [DW-1:0]      chunk [LANES];
  logic [4:0]         base;
  logic [SUM_W-1:0]   chunk_sum;
  logic [SUM_W-1:0]   total;
  logic               last;

  // Zero-based window start; 5-bit wrap keeps every lane index in range even while idle.
  always_comb begin
    base = 5'(idx_q - IW'(1));
    for (int l = 0; l < LANES; l++) begin
      chunk[l] = data[int'(5'(base + 5'(l))) + 1];
    end
  end

  lane_adder #(
    .LANES (LANES)
  ) u_lane_adder (
    .lanes (chunk),
    .sum   (chunk_sum)
  );

  assign total = acc_q + chunk_sum;
  assign last  = (state_q == ACC) && (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACC;
      ACC:     if (last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      idx_q  <= '0;
      mean_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q <= '0;
            idx_q <= IW'(1);
          end
        end
        ACC: begin
          acc_q <= total;
          idx_q <= idx_q + IW'(LANES);
          if (last) mean_q <= total[SHIFT +: DW];
        end
        default: ;
      endcase
    end
  end

  assign mean = mean_q;

endmodule

// File: tb/tb_mean32_calc.sv
// Runs a serial (LANES=1) and a parallel (LANES=32) instance side by side on shared stimulus.
module tb_mean32_calc;
  import mean32_pkg::*;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data [1:32];

  logic       ready_s, done_s, ready_p, done_p;
  logic [7:0] mean_s, mean_p;

  int errors = 0;
  int checks = 0;
  logic [7:0] q_s[$];
  logic [7:0] q_p[$];

  always #5 clk = ~clk;

  mean32_calc #(
    .LANES (1)
  ) dut_s (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .data  (data),
    .ready (ready_s),
    .done  (done_s),
    .mean  (mean_s)
  );

  mean32_calc #(
    .LANES (32)
  ) dut_p (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .data  (data),
    .ready (ready_p),
    .done  (done_p),
    .mean  (mean_p)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Caller is at a negedge. start drops at cycle 'hold'; re>0 re-raises it for one cycle.
  task automatic run_op(input string name, input int hold, input int re,
                        input logic [7:0] exp, input logic [7:0] prev);
    int cs, cp, ns, np;
    logic [7:0] e;
    cs = 0; cp = 0; ns = 0; np = 0;
    q_s.push_back(exp);
    q_p.push_back(exp);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == hold) start = 1'b0;
      if (re != 0 && c == re) start = 1'b1;
      if (re != 0 && c == re + 1) start = 1'b0;
      if (c == 1) check({name, " mean_p held"}, mean_p, prev);
      if (c == 32) check({name, " mean_s held"}, mean_s, prev);
      if (done_s === 1'b1) begin
        ns++;
        cs = c;
        if (q_s.size() != 0) begin
          e = q_s.pop_front();
          check({name, " mean_s"}, mean_s, e);
        end
      end
      if (done_p === 1'b1) begin
        np++;
        cp = c;
        if (q_p.size() != 0) begin
          e = q_p.pop_front();
          check({name, " mean_p"}, mean_p, e);
        end
      end
      if (c == 33) check({name, " ready_s low at done"}, ready_s, 0);
      if (c == 34) check({name, " ready_s after done"}, ready_s, 1);
      if (c == 3)  check({name, " ready_p after done"}, ready_p, 1);
    end
    check({name, " latency_s"}, cs, 33);
    check({name, " latency_p"}, cp, 2);
    check({name, " done_s count"}, ns, 1);
    check({name, " done_p count"}, np, 1);
  endtask

  initial begin
    for (int i = 1; i <= 32; i++) data[i] = 8'hFF;
    repeat (2) @(negedge clk);
    check("reset ready_s", ready_s, 1);
    check("reset done_s", done_s, 0);
    check("reset mean_s", mean_s, 0);
    check("reset ready_p", ready_p, 1);
    check("reset done_p", done_p, 0);
    check("reset mean_p", mean_p, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op("all_ff", 2, 0, 8'd255, 8'd0);

    for (int i = 1; i <= 32; i++) data[i] = 8'(i);
    run_op("ramp", 1, 0, 8'd16, 8'd255);

    for (int i = 1; i <= 32; i++) data[i] = (i % 2 == 1) ? 8'h00 : 8'hFF;
    run_op("alt", 1, 0, 8'd127, 8'd16);

    repeat (10) @(negedge clk);
    for (int i = 1; i <= 32; i++) data[i] = 8'h04;
    run_op("all_04", 1, 0, 8'd4, 8'd127);

    for (int i = 1; i <= 32; i++) data[i] = 8'(3 * i);
    run_op("restart_ignored", 1, 2, 8'd49, 8'd4);

    // Abort the serial instance mid-accumulate; the parallel one completes first.
    for (int i = 1; i <= 32; i++) data[i] = 8'h10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort done_p", done_p, 1);
    check("abort mean_p", mean_p, 16);
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort ready_s", ready_s, 1);
    check("abort done_s", done_s, 0);
    check("abort mean_s", mean_s, 0);
    check("abort ready_p", ready_p, 1);
    check("abort mean_p cleared", mean_p, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort no done_s", done_s, 0);
    end
    rst = 1'b1;
    @(negedge clk);

    for (int i = 1; i <= 32; i++) data[i] = 8'(255 - i);
    run_op("after_abort", 1, 0, 8'd238, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mean32_calc.md
Name: mean32_calc

Overview:
- Computes the arithmetic mean (truncated) of 32 unsigned 8-bit samples from a caller-held array.
- One parameterised block covers both the serial datapath (one sample per clock) and the parallel datapath (all 32 samples in one clock).
- Sits beside the sample store; a controller pulses start and waits for done.

Parameters:
- LANES, 1, samples summed per accumulate cycle. Legal values are 1, 2, 4, 8, 16, 32. 1 = serial variant, 32 = parallel variant.
- N_ELEM, 32, sample count. Fixed; must be a power of two.
- DW, 8, sample and mean width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE.
- data  in  unpacked array [1:32] of 8 bits  samples. Element 1 is consumed first.
- ready  out  1  high while IDLE and able to accept start.
- done  out  1  one-cycle completion pulse.
- mean  out  8  result; holds its value between completions.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, ready=1, done=0, mean=0.
  - accumulator=0, index=0.
  - An operation in progress is abandoned; no done is produced for it.
- States: IDLE, ACC, FIN.
- IDLE:
  - ready=1, done=0.
  - If start=1 at a clock edge: clear accumulator, index=1, go to ACC.
  - start is level-sensitive. If start is still high when the block returns to IDLE, a new operation begins.
- ACC (K = 32/LANES edges):
  - Each edge: accumulator += sum of data[index .. index+LANES-1]; index += LANES.
  - ready=0, done=0.
  - On the edge that adds the final chunk:
    - mean <= (accumulator + chunk_sum) >> 5, using the full 13-bit sum.
    - Go to FIN.
- FIN:
  - done=1 for exactly this one cycle; ready=0; mean is valid.
  - Next edge goes to IDLE.
- Timing:
  - Start is sampled at edge E0. done is high in the cycle after edge E0+K.
  - LANES=1: done follows 32 accumulate edges.
  - LANES=32: done follows 1 accumulate edge.
  - ready rises one cycle after done.
- start while busy (ACC or FIN) is ignored.
- Arithmetic:
  - Unsigned throughout.
  - Accumulator is 13 bits (max 32*255 = 8160), so no overflow.
  - Division is a right shift by 5, truncating toward zero; no rounding.
- data is not latched. The caller must hold data stable from the start edge until done.
- mean updates only on the completing edge. It keeps the previous result during a new operation.

Decomposition:
- Package mean32_pkg holds:
  - constants N_ELEM=32, DW=8, SUM_W=13, SHIFT=5;
  - the state enum {IDLE, ACC, FIN}.
- Sub-module lane_adder: a combinational adder tree summing LANES 8-bit inputs into a SUM_W-bit result. It is instantiated once.
- Top level holds the FSM, index counter, accumulator and mean register.

Test Plan:
- Reset, then all samples 8'hFF, pulse start for 2 cycles.
  - mean=255; done is a single-cycle pulse.
  - done occurs 32 cycles after the start edge for LANES=1, 1 cycle for LANES=32.
  - ready returns high the following cycle.
- data[i]=i for i=1..32, start.
  - sum 528, so mean=16.
  - Both LANES=1 and LANES=32 give an identical mean.
- Alternating data 0 and 255 (16 each), start.
  - sum 4080, so mean=127, confirming truncation.
- Second start pulse well after the first completion, with data changed to all 8'h04.
  - mean moves from its previous value to 4 only on the completing edge; a second done pulse is produced.
- start re-asserted during ACC.
  - Ignored; exactly one done, result unaffected.
- rst driven low mid-ACC.
  - Immediately ready=1, done=0, mean=0.
  - No done for the aborted operation.
  - A subsequent start computes correctly.
